// File: rtl/mem_stage_dmem_ctrl.sv
// mem_stage_dmem_ctrl: MEM-stage data-memory access controller for the pipelined LC-3b.
// Runs the load/store handshake with data memory, including byte lanes and the
// two-access LDI/STI (pointer read, then data access) sequence.
//
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   req_valid, req_op - instruction in MEM and its decoded memory op (held while stall=1)
//   alu_addr          - effective address from EX
//   store_data        - source register value for stores
//   dmem_rdata/resp   - memory read data / access-complete handshake
//   dmem_address/wdata/read/write/byte_enable - memory request
//   mem_data, mem_address - load result and final effective address toward MEM/WB
//   stall             - freeze the pipeline until the access completes
module mem_stage_dmem_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [15:0] alu_addr,
    input  logic [15:0] store_data,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] mem_data,
    output logic [15:0] mem_address,
    output logic        stall
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [2:0] OP_LDW = 3'b001;
    localparam logic [2:0] OP_LDB = 3'b010;
    localparam logic [2:0] OP_STW = 3'b011;
    localparam logic [2:0] OP_STB = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_STI = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IND  = 2'b01,
        ACC  = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] target_q, target_d;

    logic op_mem, op_ind, op_load, op_store, op_byte;

    // Op decode; req_op is stable for the whole access, so it is used directly
    always_comb begin
        op_ind   = (req_op == OP_LDI) || (req_op == OP_STI);
        op_load  = (req_op == OP_LDW) || (req_op == OP_LDB) || (req_op == OP_LDI);
        op_store = (req_op == OP_STW) || (req_op == OP_STB) || (req_op == OP_STI);
        op_byte  = (req_op == OP_LDB) || (req_op == OP_STB);
        op_mem   = req_valid && (op_load || op_store);
    end

    // State and latched target address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // Next state and combinational outputs
    always_comb begin
        state_d          = state_q;
        target_d         = target_q;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_byte_enable = 2'b00;
        mem_data         = '0;
        mem_address      = alu_addr;
        stall            = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_mem) begin
                    stall = 1'b1;
                    if (op_ind) begin
                        state_d = IND;
                    end else begin
                        state_d  = ACC;
                        target_d = alu_addr;
                    end
                end
            end

            // Pointer fetch for LDI/STI: always a word read
            IND: begin
                dmem_read        = 1'b1;
                dmem_address     = {alu_addr[DATA_W-1:1], 1'b0};
                dmem_byte_enable = 2'b11;
                stall            = 1'b1;
                if (dmem_resp) begin
                    target_d = dmem_rdata;
                    state_d  = ACC;
                end
            end

            ACC: begin
                dmem_read   = op_load;
                dmem_write  = op_store;
                stall       = ~dmem_resp;
                mem_address = target_q;
                if (op_byte) begin
                    dmem_address     = target_q;
                    dmem_byte_enable = target_q[0] ? 2'b10 : 2'b01;
                    dmem_wdata       = {store_data[BYTE_W-1:0], store_data[BYTE_W-1:0]};
                end else begin
                    // Misaligned word accesses silently drop bit 0
                    dmem_address     = {target_q[DATA_W-1:1], 1'b0};
                    dmem_byte_enable = 2'b11;
                    dmem_wdata       = store_data;
                end
                if (op_load) begin
                    if (!op_byte) begin
                        mem_data = dmem_rdata;
                    end else if (target_q[0]) begin
                        mem_data = {{BYTE_W{dmem_rdata[DATA_W-1]}}, dmem_rdata[DATA_W-1:BYTE_W]};
                    end else begin
                        mem_data = {{BYTE_W{dmem_rdata[BYTE_W-1]}}, dmem_rdata[BYTE_W-1:0]};
                    end
                end
                if (dmem_resp) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset forces every output quiet immediately, abandoning any access
        if (reset) begin
            dmem_address     = '0;
            dmem_wdata       = '0;
            dmem_read        = 1'b0;
            dmem_write       = 1'b0;
            dmem_byte_enable = 2'b00;
            mem_data         = '0;
            mem_address      = '0;
            stall            = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_dmem_ctrl.sv
// Testbench for mem_stage_dmem_ctrl: a behavioural data memory with a programmable
// response delay answers the DUT; expected MEM/WB results are queued per request and
// compared when the DUT drops stall.
module tb_mem_stage_dmem_ctrl;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_LDW  = 3'b001;
    localparam logic [2:0] OP_LDB  = 3'b010;
    localparam logic [2:0] OP_STW  = 3'b011;
    localparam logic [2:0] OP_STB  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_STI  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [15:0] alu_addr;
    logic [15:0] store_data;
    logic [15:0] dmem_rdata = 16'h5A5A;
    logic        dmem_resp = 1'b0;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] mem_data;
    logic [15:0] mem_address;
    logic        stall;

    mem_stage_dmem_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .alu_addr(alu_addr), .store_data(store_data), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
        .mem_data(mem_data), .mem_address(mem_address), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] addr;
    } exp_t;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } acc_t;

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];
    acc_t acc_q[$];
    logic [15:0] mem [logic [15:0]];
    int resp_delay = 0;
    int wait_cnt = 0;
    int strobe_cycles = 0;
    int write_count = 0;
    logic [15:0] waddr;
    logic [15:0] wcur;

    // Memory model: answers after resp_delay wait cycles, logs each completed access
    always @(negedge clk) begin
        if (dmem_read || dmem_write) begin
            strobe_cycles++;
            if (wait_cnt == resp_delay) begin
                wait_cnt  = 0;
                dmem_resp = 1'b1;
                waddr = {dmem_address[15:1], 1'b0};
                if (dmem_read) begin
                    dmem_rdata = mem.exists(waddr) ? mem[waddr] : 16'h0000;
                end else begin
                    wcur = mem.exists(waddr) ? mem[waddr] : 16'h0000;
                    if (dmem_byte_enable[1]) wcur[15:8] = dmem_wdata[15:8];
                    if (dmem_byte_enable[0]) wcur[7:0]  = dmem_wdata[7:0];
                    mem[waddr] = wcur;
                    write_count++;
                    dmem_rdata = 16'h5A5A;
                end
                acc_q.push_back('{dmem_write, dmem_address, dmem_byte_enable, dmem_wdata});
            end else begin
                wait_cnt++;
                dmem_resp  = 1'b0;
                dmem_rdata = 16'h5A5A;
            end
        end else begin
            wait_cnt   = 0;
            dmem_resp  = 1'b0;
            dmem_rdata = 16'h5A5A;
        end
    end

    function automatic exp_t pop_exp();
        if (exp_q.size() == 0) return exp_t'('x);
        return exp_q.pop_front();
    endfunction

    function automatic acc_t pop_acc();
        if (acc_q.size() == 0) return acc_t'('x);
        return acc_q.pop_front();
    endfunction

    // Issue one request at the next clock and wait (bounded) for stall to drop
    task automatic run_req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] sd,
                           output int stalls, output logic done,
                           output logic [15:0] md, output logic [15:0] ma);
        stalls = 0; done = 1'b0; md = '0; ma = '0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; alu_addr = a; store_data = sd;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (!stall) begin
                done = 1'b1; md = mem_data; ma = mem_address;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = OP_NONE;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_op = OP_LDW; alu_addr = 16'h1234; store_data = 16'hFFFF;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall); end
        checks++; if ({dmem_read, dmem_write} !== 2'b00) begin failures++; $display("FAIL rst_strobes got=%b exp=00", {dmem_read, dmem_write}); end
        checks++; if ({dmem_address, dmem_wdata, dmem_byte_enable} !== 34'h0) begin failures++; $display("FAIL rst_dmem got=%h/%h/%b exp=0", dmem_address, dmem_wdata, dmem_byte_enable); end
        checks++; if ({mem_data, mem_address} !== 32'h0) begin failures++; $display("FAIL rst_memwb got=%h/%h exp=0/0", mem_data, mem_address); end
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0; req_op = OP_NONE;
    endtask

    task automatic test_ldw();
        int st; logic dn; logic [15:0] md, ma; exp_t e; acc_t a;
        resp_delay = 0; strobe_cycles = 0;
        exp_q.push_back('{16'hBEEF, 16'h3002});
        run_req(OP_LDW, 16'h3002, 16'h0000, st, dn, md, ma);
        e = pop_exp(); a = pop_acc();
        checks++; if (dn !== 1'b1) begin failures++; $display("FAIL ldw_done got=%b exp=1", dn); end
        checks++; if (st !== 1) begin failures++; $display("FAIL ldw_stall_cycles got=%0d exp=1", st); end
        checks++; if (strobe_cycles !== 1) begin failures++; $display("FAIL ldw_read_cycles got=%0d exp=1", strobe_cycles); end
        checks++; if ({md, ma} !== {e.data, e.addr}) begin failures++; $display("FAIL ldw_memwb got=%h/%h exp=%h/%h", md, ma, e.data, e.addr); end
        checks++; if ({a.wr, a.addr, a.be} !== {1'b0, 16'h3002, 2'b11}) begin failures++; $display("FAIL ldw_access got=%b/%h/%b exp=0/3002/11", a.wr, a.addr, a.be); end
        // Misaligned word load: memory sees bit 0 cleared, MEM/WB sees the raw target
        exp_q.push_back('{16'hBEEF, 16'h3003});
        run_req(OP_LDW, 16'h3003, 16'h0000, st, dn, md, ma);
        e = pop_exp(); a = pop_acc();
        checks++; if ({dn, md, ma} !== {1'b1, e.data, e.addr}) begin failures++; $display("FAIL ldw_misaligned_memwb got=%b/%h/%h exp=1/%h/%h", dn, md, ma, e.data, e.addr); end
        checks++; if (a.addr !== 16'h3002) begin failures++; $display("FAIL ldw_misaligned_addr got=%h exp=3002", a.addr); end
        go_idle();
    endtask

    task automatic test_ldb();
        int st; logic dn; logic [15:0] md, ma; exp_t e; acc_t a;
        exp_q.push_back('{16'hFF85, 16'h4001});
        run_req(OP_LDB, 16'h4001, 16'h0000, st, dn, md, ma);
        e = pop_exp(); a = pop_acc();
        checks++; if ({dn, md, ma} !== {1'b1, e.data, e.addr}) begin failures++; $display("FAIL ldb_odd_memwb got=%b/%h/%h exp=1/%h/%h", dn, md, ma, e.data, e.addr); end
        checks++; if ({a.wr, a.addr, a.be} !== {1'b0, 16'h4001, 2'b10}) begin failures++; $display("FAIL ldb_odd_access got=%b/%h/%b exp=0/4001/10", a.wr, a.addr, a.be); end
        exp_q.push_back('{16'h0012, 16'h4000});
        run_req(OP_LDB, 16'h4000, 16'h0000, st, dn, md, ma);
        e = pop_exp(); a = pop_acc();
        checks++; if ({dn, md, ma} !== {1'b1, e.data, e.addr}) begin failures++; $display("FAIL ldb_even_memwb got=%b/%h/%h exp=1/%h/%h", dn, md, ma, e.data, e.addr); end
        checks++; if ({a.addr, a.be} !== {16'h4000, 2'b01}) begin failures++; $display("FAIL ldb_even_access got=%h/%b exp=4000/01", a.addr, a.be); end
        go_idle();
    endtask

    task automatic test_stb();
        int st; logic dn; logic [15:0] md, ma; exp_t e; acc_t a;
        exp_q.push_back('{16'h0000, 16'h5003});
        run_req(OP_STB, 16'h5003, 16'h12A7, st, dn, md, ma);
        e = pop_exp(); a = pop_acc();
        checks++; if ({dn, md, ma} !== {1'b1, e.data, e.addr}) begin failures++; $display("FAIL stb_memwb got=%b/%h/%h exp=1/%h/%h", dn, md, ma, e.data, e.addr); end
        checks++; if (a !== acc_t'({1'b1, 16'h5003, 2'b10, 16'hA7A7})) begin failures++; $display("FAIL stb_access got=%b/%h/%b/%h exp=1/5003/10/a7a7", a.wr, a.addr, a.be, a.wdata); end
        checks++; if (mem[16'h5002] !== 16'hA700) begin failures++; $display("FAIL stb_mem got=%h exp=a700", mem[16'h5002]); end
        go_idle();
    endtask

    task automatic test_ldi();
        int st; logic dn; logic [15:0] md, ma; exp_t e; acc_t a1, a2;
        resp_delay = 2;
        exp_q.push_back('{16'h1234, 16'h7004});
        run_req(OP_LDI, 16'h6000, 16'h0000, st, dn, md, ma);
        e = pop_exp(); a1 = pop_acc(); a2 = pop_acc();
        checks++; if (dn !== 1'b1) begin failures++; $display("FAIL ldi_done got=%b exp=1", dn); end
        checks++; if (st !== 6) begin failures++; $display("FAIL ldi_stall_cycles got=%0d exp=6", st); end
        checks++; if ({md, ma} !== {e.data, e.addr}) begin failures++; $display("FAIL ldi_memwb got=%h/%h exp=%h/%h", md, ma, e.data, e.addr); end
        checks++; if ({a1.wr, a1.addr, a2.wr, a2.addr} !== {1'b0, 16'h6000, 1'b0, 16'h7004}) begin failures++; $display("FAIL ldi_addrs got=%h,%h exp=6000,7004", a1.addr, a2.addr); end
        resp_delay = 0;
        go_idle();
    endtask

    task automatic test_back_to_back();
        int st; logic dn; logic [15:0] md, ma; exp_t e; acc_t a;
        acc_q.delete();
        exp_q.push_back('{16'h0000, 16'h0010});
        run_req(OP_NONE, 16'h0010, 16'hCAFE, st, dn, md, ma);
        e = pop_exp();
        checks++; if ({dn, st[3:0], dmem_read, dmem_write} !== {1'b1, 4'd0, 2'b00}) begin failures++; $display("FAIL none_nostall got=%b/%0d/%b exp=1/0/00", dn, st, {dmem_read, dmem_write}); end
        checks++; if ({md, ma} !== {e.data, e.addr}) begin failures++; $display("FAIL none_memwb got=%h/%h exp=%h/%h", md, ma, e.data, e.addr); end
        exp_q.push_back('{16'h0000, 16'h0010});
        run_req(OP_STW, 16'h0010, 16'hCAFE, st, dn, md, ma);
        e = pop_exp(); a = pop_acc();
        checks++; if ({dn, md, ma} !== {1'b1, e.data, e.addr}) begin failures++; $display("FAIL stw_memwb got=%b/%h/%h exp=1/%h/%h", dn, md, ma, e.data, e.addr); end
        checks++; if (a !== acc_t'({1'b1, 16'h0010, 2'b11, 16'hCAFE})) begin failures++; $display("FAIL stw_access got=%b/%h/%b/%h exp=1/0010/11/cafe", a.wr, a.addr, a.be, a.wdata); end
        checks++; if (mem[16'h0010] !== 16'hCAFE) begin failures++; $display("FAIL stw_mem got=%h exp=cafe", mem[16'h0010]); end
        // Reserved op behaves as NONE, then an STI follows immediately
        exp_q.push_back('{16'h0000, 16'h0044});
        run_req(OP_RSV, 16'h0044, 16'h1111, st, dn, md, ma);
        e = pop_exp();
        checks++; if ({dn, st[3:0], md, ma} !== {1'b1, 4'd0, e.data, e.addr}) begin failures++; $display("FAIL rsv_none got=%b/%0d/%h/%h exp=1/0/%h/%h", dn, st, md, ma, e.data, e.addr); end
        exp_q.push_back('{16'h0000, 16'h0030});
        run_req(OP_STI, 16'h0020, 16'h55AA, st, dn, md, ma);
        e = pop_exp();
        checks++; if ({dn, st[3:0], md, ma} !== {1'b1, 4'd2, e.data, e.addr}) begin failures++; $display("FAIL sti_memwb got=%b/%0d/%h/%h exp=1/2/%h/%h", dn, st, md, ma, e.data, e.addr); end
        checks++; if (mem[16'h0030] !== 16'h55AA) begin failures++; $display("FAIL sti_mem got=%h exp=55aa", mem[16'h0030]); end
        go_idle();
    endtask

    task automatic test_reset_mid_access();
        int st; int wc0; logic dn; logic [15:0] md, ma; exp_t e;
        resp_delay = 3;
        wc0 = write_count;
        acc_q.delete();
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = OP_STI; alu_addr = 16'h0F00; store_data = 16'hDEAD;
        @(posedge clk); #1;
        checks++; if ({stall, dmem_read, dmem_address} !== {2'b11, 16'h0F00}) begin failures++; $display("FAIL sti_ind got=%b/%b/%h exp=1/1/0f00", stall, dmem_read, dmem_address); end
        reset = 1'b1;
        #1;
        checks++; if ({stall, dmem_read, dmem_write} !== 3'b000) begin failures++; $display("FAIL rst_mid_drop got=%b exp=000", {stall, dmem_read, dmem_write}); end
        checks++; if ({mem_data, mem_address} !== 32'h0) begin failures++; $display("FAIL rst_mid_memwb got=%h/%h exp=0/0", mem_data, mem_address); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; req_valid = 1'b0; req_op = OP_NONE; resp_delay = 0;
        repeat (3) @(posedge clk);
        checks++; if ({write_count - wc0, acc_q.size()} !== {32'd0, 32'd0}) begin failures++; $display("FAIL rst_mid_nowrite got=%0d writes %0d accesses exp=0 0", write_count - wc0, acc_q.size()); end
        exp_q.push_back('{16'hBEEF, 16'h3002});
        run_req(OP_LDW, 16'h3002, 16'h0000, st, dn, md, ma);
        e = pop_exp();
        checks++; if ({dn, st[3:0], md, ma} !== {1'b1, 4'd1, e.data, e.addr}) begin failures++; $display("FAIL post_rst_ldw got=%b/%0d/%h/%h exp=1/1/%h/%h", dn, st, md, ma, e.data, e.addr); end
        go_idle();
    endtask

    initial begin
        mem[16'h3002] = 16'hBEEF;
        mem[16'h4000] = 16'h8512;
        mem[16'h5002] = 16'h0000;
        mem[16'h6000] = 16'h7004;
        mem[16'h7004] = 16'h1234;
        mem[16'h0020] = 16'h0030;
        mem[16'h0F00] = 16'h0F10;
        test_reset();
        test_ldw();
        test_ldb();
        test_stb();
        test_ldi();
        test_back_to_back();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_stage_dmem_ctrl.md
# mem_stage_dmem_ctrl

Data-memory access controller for the MEM stage of the pipelined LC-3b datapath. It takes the decoded memory operation for the instruction currently in MEM and runs the load/store handshake with data memory, including byte lanes and the two-access LDI/STI sequence. It drives the load data and effective address into the MEM/WB pipeline register, and asserts `stall` to freeze the pipeline until the access completes.

## Interface
Parameters: none.
- `clk` in 1: single clock; all state updates on its rising edge
- `reset` in 1: asynchronous, active-high reset
- `req_valid` in 1: a valid instruction occupies MEM; `req_op` and the data inputs are held stable while `stall`=1
- `req_op` in 3: 000 NONE, 001 LDW, 010 LDB, 011 STW, 100 STB, 101 LDI, 110 STI; 111 is treated as NONE
- `alu_addr` in 16: effective address from EX
- `store_data` in 16: source register value for stores
- `dmem_rdata` in 16: memory read data, valid when `dmem_resp`=1
- `dmem_resp` in 1: memory completes the current read or write this cycle
- `dmem_address` out 16: memory address
- `dmem_wdata` out 16: memory write data
- `dmem_read` out 1: read strobe
- `dmem_write` out 1: write strobe
- `dmem_byte_enable` out 2: [1] enables the high byte, [0] enables the low byte
- `mem_data` out 16: load result to MEM/WB; 0x0000 for non-loads
- `mem_address` out 16: final effective address to MEM/WB
- `stall` out 1: freeze the pipeline; MEM/WB captures only when it is 0

## Operation
- FSM states: IDLE, IND, ACC.
- IDLE
  - `dmem_read`=`dmem_write`=0.
  - NONE, or `req_valid`=0: `stall`=0, `mem_address`=`alu_addr`, `mem_data`=0. Zero latency.
  - LDW/LDB/STW/STB: `stall`=1, go to ACC. Latch target=`alu_addr`.
  - LDI/STI: `stall`=1, go to IND.
- IND
  - `dmem_read`=1, `dmem_address`={`alu_addr`[15:1],0}, byte_enable=11, `stall`=1.
  - On `dmem_resp`: latch target=`dmem_rdata`, go to ACC.
- ACC
  - Strobe follows the op: loads assert `dmem_read`, stores assert `dmem_write`.
  - Word ops (LDW/STW/LDI/STI): `dmem_address`={target[15:1],0}, byte_enable=11, `dmem_wdata`=`store_data`.
  - Byte ops (LDB/STB): `dmem_address`=target, byte_enable=target[0]?10:01, `dmem_wdata`={`store_data`[7:0],`store_data`[7:0]}.
  - `stall`=~`dmem_resp`.
  - On `dmem_resp`: go to IDLE. In that same cycle `mem_data` and `mem_address`=target are valid for MEM/WB capture.
- Load data
  - LDW/LDI: `mem_data`=`dmem_rdata`.
  - LDB: `mem_data` = sign-extended `dmem_rdata`[15:8] if target[0]=1, else sign-extended `dmem_rdata`[7:0].
  - Stores: `mem_data`=0.
- `dmem_address`, `dmem_wdata` and byte_enable are 0 in IDLE.
- The pipeline advances exactly when `stall`=0, so the request seen in IDLE after a completion is always a new instruction.
- Strobes stay asserted and stable until `dmem_resp`. `dmem_resp` outside IND/ACC is ignored.

## Timing
- Reset (async, immediate)
  - State=IDLE, target=0.
  - `dmem_read`=`dmem_write`=0, `dmem_address`=`dmem_wdata`=0, byte_enable=00.
  - `stall`=0, `mem_data`=0, `mem_address`=0 while reset is held.
  - Reset during IND/ACC abandons the access with no further strobes.
- Simple load/store with same-cycle response
  - Request at cycle N (stall=1).
  - ACC and strobe at N+1. `dmem_resp`@N+1 gives stall=0; MEM/WB captures at the end of N+1.
  - Minimum 2 cycles.
- LDI/STI: minimum 3 cycles (IDLE, IND, ACC). Each wait cycle without `dmem_resp` adds one cycle.
- Outputs toward MEM/WB are combinational from state, the latched target and `dmem_rdata`. They are valid only in the cycle `stall`=0.
- Byte alignment
  - A misaligned word access silently clears bit 0 of `dmem_address`.
  - `mem_address` still reports the unmodified target.

## Test plan
- LDW: `alu_addr`=0x3002, `dmem_rdata`=0xBEEF, resp on first strobe cycle. Required: `dmem_address`=0x3002, `dmem_read`=1 for 1 cycle, `stall` high 1 cycle, `mem_data`=0xBEEF and `mem_address`=0x3002 in the completion cycle.
- LDB odd: `alu_addr`=0x4001, `dmem_rdata`=0x8512. Required: `mem_data`=0xFF85, byte_enable=10. Repeat with `alu_addr`=0x4000: `mem_data`=0x0012.
- STB: `alu_addr`=0x5003, `store_data`=0x12A7. Required: `dmem_write`=1, `dmem_address`=0x5003, `dmem_wdata`=0xA7A7, byte_enable=10, `mem_data`=0.
- LDI: `alu_addr`=0x6000, first read returns 0x7004, second read returns 0x1234, resp delayed 2 cycles each time. Required: addresses 0x6000 then 0x7004, `stall` high 6 cycles, `mem_data`=0x1234, `mem_address`=0x7004.
- NONE op back-to-back with STW (`alu_addr`=0x0010, `store_data`=0xCAFE). Required: NONE gives `stall`=0 and no strobe; STW writes 0xCAFE at 0x0010.
- Reset asserted in IND of STI. Required: strobes and `stall` drop immediately and no write is issued. After release, a fresh LDW completes normally.
